// File: rtl/vec_seq_pkg.sv
// Shared definitions for the test vector sequencer: default geometry, loop counter width
// and the playback FSM state encoding.
package vec_seq_pkg;

    localparam int DEF_DEPTH = 1024;
    localparam int DEF_AW    = 10;
    localparam int DEF_DW    = 8;
    localparam int LOOP_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/vec_seq_ram.sv
// Single-port vector store, DEPTH x DW, synchronous write and registered read.
// rdata only updates on a read enable, so it holds the last word fetched.
module vec_seq_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/test_vector_sequencer.sv
// Test vector store with looped in-order playback to the result analyzer.
// Optional VEC_SEQ_CKSUM_EN adds load_cksum, the modulo-2^DW sum of accepted load bytes.
module test_vector_sequencer
    import vec_seq_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_clr,
    input  logic              load_valid,
    input  logic [DW-1:0]     load_data,
    output logic              load_ready,
    input  logic              start,
    input  logic [LOOP_W-1:0] loop_cnt,
    input  logic              abort,
    output logic              vec_valid,
    output logic [DW-1:0]     vec_data,
    output logic [AW-1:0]     vec_addr,
    input  logic              vec_ready,
    output logic [AW:0]       vec_count,
    output logic              busy,
    output logic [1:0]        dbg_state,
    output logic              done
`ifdef VEC_SEQ_CKSUM_EN
    ,
    output logic [DW-1:0]     load_cksum
`endif
);

    state_t            state, state_nxt;
    logic [AW-1:0]     rd_addr;
    logic [LOOP_W-1:0] iss_pass, pass_cnt, loops_eff;
    logic              iss_done;
    logic              rv, sv;
    logic [AW-1:0]     ra, sa, ram_addr;
    logic [DW-1:0]     sd, rdata;
    logic [2:0]        occ;
    logic              is_idle, in_run, clr_fire, ld_fire;
    logic              pop, hs, issue, last_iss, last_out, final_hs;

    assign is_idle   = (state == ST_IDLE);
    assign in_run    = (state == ST_RUN);
    assign load_ready = is_idle & (vec_count != (AW+1)'(DEPTH)) & ~start & ~load_clr;
    assign ld_fire   = load_valid & load_ready;
    assign clr_fire  = is_idle & load_clr & ~start;
    assign loops_eff = (loop_cnt == '0) ? LOOP_W'(1) : loop_cnt;
    assign dbg_state = state;

    // Handshake: a vector transfers on a clock edge where vec_valid & vec_ready; vec_valid,
    // vec_data and vec_addr never depend combinationally on vec_ready and hold until transfer.
    assign pop      = vec_valid & vec_ready;
    assign hs       = in_run & pop & ~abort;
    assign last_out = ({1'b0, vec_addr} == vec_count - (AW+1)'(1));
    assign final_hs = hs & last_out & (pass_cnt == LOOP_W'(1));
    assign last_iss = ({1'b0, rd_addr} == vec_count - (AW+1)'(1));

    // Only fetch when the word landing next cycle is guaranteed a slot in output+skid.
    assign occ   = 3'(vec_valid) + 3'(sv) + 3'(rv);
    assign issue = in_run & ~abort & ~iss_done & (occ <= 3'd1 + 3'(pop));

    assign ram_addr = in_run ? rd_addr : vec_count[AW-1:0];

    vec_seq_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_ram (
        .clk   (clk),
        .we    (ld_fire),
        .re    (issue),
        .addr  (ram_addr),
        .wdata (load_data),
        .rdata (rdata)
    );

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (vec_count != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (final_hs) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_count <= '0;
        end else if (clr_fire) begin
            vec_count <= '0;
        end else if (ld_fire) begin
            vec_count <= vec_count + (AW+1)'(1);
        end
    end

`ifdef VEC_SEQ_CKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_cksum <= '0;
        end else if (clr_fire) begin
            load_cksum <= '0;
        end else if (ld_fire) begin
            load_cksum <= load_cksum + load_data;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            rd_addr   <= '0;
            iss_pass  <= '0;
            pass_cnt  <= '0;
            iss_done  <= 1'b0;
            rv        <= 1'b0;
            ra        <= '0;
            sv        <= 1'b0;
            sd        <= '0;
            sa        <= '0;
            vec_valid <= 1'b0;
            vec_data  <= '0;
            vec_addr  <= '0;
        end else begin
            state <= state_nxt;
            if (is_idle && start) begin
                rd_addr  <= '0;
                iss_pass <= loops_eff;
                pass_cnt <= loops_eff;
                iss_done <= 1'b0;
            end
            // Fetch side runs its own pass count so it can stop after the last word.
            if (issue) begin
                if (last_iss) begin
                    rd_addr <= '0;
                    if (iss_pass == LOOP_W'(1)) begin
                        iss_done <= 1'b1;
                    end else begin
                        iss_pass <= iss_pass - LOOP_W'(1);
                    end
                end else begin
                    rd_addr <= rd_addr + AW'(1);
                end
            end
            rv <= issue;
            ra <= rd_addr;
            if (hs && last_out) begin
                pass_cnt <= pass_cnt - LOOP_W'(1);
            end
            if (!in_run || abort) begin
                vec_valid <= 1'b0;
                sv        <= 1'b0;
                rv        <= 1'b0;
            end else if (!vec_valid || pop) begin
                if (sv) begin
                    vec_valid <= 1'b1;
                    vec_data  <= sd;
                    vec_addr  <= sa;
                    sv        <= rv;
                    sd        <= rdata;
                    sa        <= ra;
                end else if (rv) begin
                    vec_valid <= 1'b1;
                    vec_data  <= rdata;
                    vec_addr  <= ra;
                end else begin
                    vec_valid <= 1'b0;
                end
            end else if (rv) begin
                sv <= 1'b1;
                sd <= rdata;
                sa <= ra;
            end
        end
    end

endmodule

// File: tb/tb_test_vector_sequencer.sv
// Bench for test_vector_sequencer: directed loads/playbacks against a queue-based model of the
// expected vector stream, plus hand-computed checks. Build with VEC_SEQ_CKSUM_EN to cover load_cksum.
module tb_test_vector_sequencer;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int DW    = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_clr = 1'b0;
    logic          load_valid = 1'b0;
    logic [DW-1:0] load_data = '0;
    logic          start = 1'b0;
    logic [7:0]    loop_cnt = '0;
    logic          abort = 1'b0;
    logic          vec_ready = 1'b0;
    logic          load_ready, vec_valid, busy, done;
    logic [DW-1:0] vec_data;
    logic [AW-1:0] vec_addr;
    logic [AW:0]   vec_count;
    logic [1:0]    dbg_state;
`ifdef VEC_SEQ_CKSUM_EN
    logic [DW-1:0] load_cksum;
`endif

    test_vector_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .load_clr   (load_clr),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .start      (start),
        .loop_cnt   (loop_cnt),
        .abort      (abort),
        .vec_valid  (vec_valid),
        .vec_data   (vec_data),
        .vec_addr   (vec_addr),
        .vec_ready  (vec_ready),
        .vec_count  (vec_count),
        .busy       (busy),
        .dbg_state  (dbg_state),
        .done       (done)
`ifdef VEC_SEQ_CKSUM_EN
        ,
        .load_cksum (load_cksum)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout need completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_fail = 0;
    logic [AW+DW-1:0] exp_q[$];
    logic [DW-1:0] m_mem [DEPTH];
    int  m_count = 0;
    bit  m_running = 0;
    bit  m_done = 0;
    bit  nxt_done;
    bit  exp_rdy;
    int  passes;
    logic [DW-1:0] m_cksum = '0;
    int  start_cyc = 0;
    int  hs_data[$], hs_addr[$], hs_cyc[$], done_log[$];
    int  hs_base = 0;
    int  done_base = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, need 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int q_at(input int q[$], input int i);
        return (i >= 0 && i < q.size()) ? q[i] : -1;
    endfunction

    // Model: the expected stream is every stored byte in address order, repeated per pass.
    always @(negedge clk) begin
        if (rst) begin
            m_count   = 0;
            m_running = 0;
            m_done    = 0;
            m_cksum   = '0;
            exp_q.delete();
        end else begin
            exp_rdy = !m_running && !m_done && (m_count != DEPTH) && !start && !load_clr;
            check("load_ready", load_ready, exp_rdy);
            check("busy", busy, m_running);
            check("done", done, m_done);
            check("vec_count", vec_count, m_count);
`ifdef VEC_SEQ_CKSUM_EN
            check("load_cksum", load_cksum, m_cksum);
`endif
            if (!m_running) begin
                check("vec_valid_off", vec_valid, 0);
            end else if (vec_valid) begin
                if (exp_q.size() == 0) begin
                    check("vec_extra", vec_valid, 0);
                end else begin
                    check("vec_data", vec_data, exp_q[0][DW-1:0]);
                    check("vec_addr", vec_addr, exp_q[0][AW+DW-1:DW]);
                end
            end
            if (done) done_log.push_back(cyc);

            nxt_done = 0;
            if (!m_done) begin
                if (m_running) begin
                    if (abort) begin
                        m_running = 0;
                        exp_q.delete();
                    end else if (vec_valid && vec_ready && exp_q.size() > 0) begin
                        hs_data.push_back(int'(vec_data));
                        hs_addr.push_back(int'(vec_addr));
                        hs_cyc.push_back(cyc);
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) begin
                            m_running = 0;
                            nxt_done  = 1;
                        end
                    end
                end else if (start) begin
                    start_cyc = cyc + 1;
                    if (m_count == 0) begin
                        nxt_done = 1;
                    end else begin
                        m_running = 1;
                        passes = (loop_cnt == 0) ? 1 : int'(loop_cnt);
                        for (int p = 0; p < passes; p++)
                            for (int a = 0; a < m_count; a++)
                                exp_q.push_back({AW'(a), m_mem[a]});
                    end
                end else if (load_clr) begin
                    m_count = 0;
                    m_cksum = '0;
                end else if (load_valid && m_count < DEPTH) begin
                    m_mem[m_count] = load_data;
                    m_count++;
                    m_cksum = m_cksum + load_data;
                end
            end
            m_done = nxt_done;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_seq(input int n, input int first);
        for (int i = 0; i < n; i++) begin
            tick();
            load_valid = 1'b1;
            load_data  = DW'(first + i);
        end
        tick();
        load_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        tick();
        load_clr = 1'b1;
        tick();
        load_clr = 1'b0;
    endtask

    task automatic wait_idle(input bit toggle, input int max_cyc);
        int n;
        n = 0;
        while ((busy || done) && n < max_cyc) begin
            tick();
            if (toggle) vec_ready = ~vec_ready;
            n++;
        end
        check("idle_timeout", 32'(n < max_cyc), 1);
        vec_ready = 1'b1;
        tick();
    endtask

    task automatic play(input int loops, input bit toggle, input int max_cyc);
        hs_base   = hs_data.size();
        done_base = done_log.size();
        vec_ready = 1'b1;
        tick();
        start    = 1'b1;
        loop_cnt = 8'(loops);
        tick();
        start = 1'b0;
        wait_idle(toggle, max_cyc);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        logic [7:0] ck_bytes [3];
        ck_bytes = '{8'hA5, 8'h5B, 8'h01};

        repeat (2) @(posedge clk);
        #1;
        check("rst_vec_valid", vec_valid, 0);
        check("rst_vec_data", vec_data, 0);
        check("rst_vec_addr", vec_addr, 0);
        check("rst_vec_count", vec_count, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;

`ifdef VEC_SEQ_CKSUM_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            load_valid = 1'b1;
            load_data  = ck_bytes[i];
        end
        tick();
        load_valid = 1'b0;
        check("cksum_a55b01", load_cksum, 8'h01);
        pulse_clr();
        check("cksum_clr", load_cksum, 8'h00);
`endif

        // Four vectors, single pass, vec_ready held high
        load_seq(4, 'h10);
        check("t1_count", vec_count, 4);
        play(1, 0, 50);
        check("t1_hs_n", hs_data.size() - hs_base, 4);
        for (int i = 0; i < 4; i++) begin
            check("t1_data", q_at(hs_data, hs_base + i), 32'h10 + i);
            check("t1_addr", q_at(hs_addr, hs_base + i), i);
            check("t1_cyc", q_at(hs_cyc, hs_base + i), start_cyc + 2 + i);
        end
        check("t1_done_n", done_log.size() - done_base, 1);
        check("t1_done_cyc", q_at(done_log, done_base), start_cyc + 6);

        // Three passes with vec_ready toggling
        play(3, 1, 200);
        check("t2_hs_n", hs_data.size() - hs_base, 12);
        for (int i = 0; i < 12; i++) begin
            check("t2_addr", q_at(hs_addr, hs_base + i), i % 4);
            check("t2_data", q_at(hs_data, hs_base + i), 32'h10 + (i % 4));
        end
        check("t2_done_n", done_log.size() - done_base, 1);

        // Abort on the third handshake cycle
        hs_base   = hs_data.size();
        done_base = done_log.size();
        vec_ready = 1'b1;
        tick();
        start    = 1'b1;
        loop_cnt = 8'd1;
        tick();
        start = 1'b0;
        n = 0;
        while (!vec_valid && n < 10) begin
            tick();
            n++;
        end
        check("ab_valid_seen", vec_valid, 1);
        tick();
        tick();
        check("ab_addr3", vec_addr, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_valid_off", vec_valid, 0);
        check("ab_busy", busy, 0);
        repeat (3) tick();
        check("ab_hs_n", hs_data.size() - hs_base, 2);
        check("ab_done_n", done_log.size() - done_base, 0);
        check("ab_count", vec_count, 4);
        play(1, 0, 50);
        check("ab_restart_addr", q_at(hs_addr, hs_base), 0);
        check("ab_restart_n", hs_data.size() - hs_base, 4);

        // Empty store: start (with a competing load byte) goes straight to done
        pulse_clr();
        check("t4_clr_count", vec_count, 0);
        hs_base   = hs_data.size();
        done_base = done_log.size();
        tick();
        start      = 1'b1;
        loop_cnt   = 8'd2;
        load_valid = 1'b1;
        load_data  = 8'h99;
        tick();
        start      = 1'b0;
        load_valid = 1'b0;
        check("t4_done_now", done, 1);
        check("t4_no_valid", vec_valid, 0);
        check("t4_count_kept", vec_count, 0);
        wait_idle(0, 10);
        check("t4_done_cyc", q_at(done_log, done_base), start_cyc);
        check("t4_hs_n", hs_data.size() - hs_base, 0);

        // loop_cnt = 0 plays exactly one pass
        load_seq(2, 'h77);
        play(0, 0, 50);
        check("t5_hs_n", hs_data.size() - hs_base, 2);
        check("t5_data1", q_at(hs_data, hs_base + 1), 32'h78);
        check("t5_done_n", done_log.size() - done_base, 1);

        // Overfill: 1030 offered, 1024 kept; two passes wrap 1023 -> 0 at full rate
        pulse_clr();
        load_seq(1030, 0);
        check("t3_count_full", vec_count, 1024);
        check("t3_ready_full", load_ready, 0);
        play(2, 0, 3000);
        check("t3_hs_n", hs_data.size() - hs_base, 2048);
        check("t3_addr_last", q_at(hs_addr, hs_base + 1023), 1023);
        check("t3_data_last", q_at(hs_data, hs_base + 1023), 32'hff);
        check("t3_addr_wrap", q_at(hs_addr, hs_base + 1024), 0);
        check("t3_data_wrap", q_at(hs_data, hs_base + 1024), 0);
        check("t3_rate", q_at(hs_cyc, hs_base + 2047), q_at(hs_cyc, hs_base) + 2047);

        // Asynchronous reset mid-run
        tick();
        start    = 1'b1;
        loop_cnt = 8'd1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("mr_busy_before", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("mr_vec_valid", vec_valid, 0);
        check("mr_vec_data", vec_data, 0);
        check("mr_vec_addr", vec_addr, 0);
        check("mr_vec_count", vec_count, 0);
        check("mr_busy", busy, 0);
        check("mr_done", done, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) tick();
        check("mr_count_after", vec_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
